// File: rtl/mux_scanner_pkg.sv
// Shared types and constants for the mux_scanner channel sampler.
package mux_scanner_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Next channel index, wrapping from n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_scanner_if.sv
// Control, channel data and sample handshake bundle for mux_scanner.
// ch_mask is present only when MUX_SCANNER_MASK_EN is defined.
interface mux_scanner_if #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 8
);
    localparam int unsigned SW = $clog2(N);

    logic            en;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [N*W-1:0]  din;
    logic            dout_ready;
    logic [W-1:0]    dout;
    logic            dout_valid;
    logic [SW-1:0]   dout_ch;
    logic            dout_last;
`ifdef MUX_SCANNER_MASK_EN
    logic [N-1:0]    ch_mask;

    modport master (output en, mode, sel, din, dout_ready, ch_mask,
                    input  dout, dout_valid, dout_ch, dout_last);
    modport slave  (input  en, mode, sel, din, dout_ready, ch_mask,
                    output dout, dout_valid, dout_ch, dout_last);
`else
    modport master (output en, mode, sel, din, dout_ready,
                    input  dout, dout_valid, dout_ch, dout_last);
    modport slave  (input  en, mode, sel, din, dout_ready,
                    output dout, dout_valid, dout_ch, dout_last);
`endif
endinterface

// File: rtl/mux_nto1.sv
// Combinational N:1 selector of W-bit channels; sel is expected to be < N.
module mux_nto1 #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 8
) (
    input  logic [N*W-1:0]       din,
    input  logic [$clog2(N)-1:0] sel,
    output logic [W-1:0]         y
);
    localparam int unsigned SW = $clog2(N);

    always_comb begin
        y = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (sel == SW'(k)) y = din[k*W +: W];
        end
    end
endmodule

// File: rtl/mux_scanner.sv
// Manual/auto-scan channel sampler with a one-deep valid/ready output register.
// Optional channel masking is enabled by defining MUX_SCANNER_MASK_EN.
module mux_scanner #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 8
) (
    input logic          clk,
    input logic          rst,
    mux_scanner_if.slave bus
);
    import mux_scanner_pkg::*;

    localparam int unsigned SW = $clog2(N);

    state_t        state;
    logic [SW-1:0] ptr;
    logic [W-1:0]  dout_q;
    logic [SW-1:0] dout_ch_q;
    logic          dout_last_q;
    logic          dout_valid_q;

    logic [SW-1:0] man_ch;
    logic [SW-1:0] scan_ch;
    logic [SW-1:0] cap_ch;
    logic [SW-1:0] ptr_adv;
    logic [W-1:0]  cap_data;
    logic          man_ok;
    logic          scan_ok;
    logic          scan_last;
    logic          cap_last;
    logic          cap_ok;
    logic          do_cap;
`ifdef MUX_SCANNER_MASK_EN
    logic [SW-1:0] hi_ch;
`endif

    // Channel selection: out-of-range manual selects fall back to channel 0.
    always_comb begin
        man_ch = ({1'b0, bus.sel} < (SW+1)'(N)) ? bus.sel : '0;
`ifdef MUX_SCANNER_MASK_EN
        scan_ok = 1'b0;
        scan_ch = '0;
        hi_ch   = '0;
        // Descending search so the nearest enabled channel at or after ptr wins.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(ptr) + i) % int'(N);
            if (bus.ch_mask[idx]) begin
                scan_ok = 1'b1;
                scan_ch = SW'(idx);
            end
        end
        for (int k = 0; k < int'(N); k++) begin
            if (bus.ch_mask[k]) hi_ch = SW'(k);
        end
        scan_last = scan_ok && (scan_ch == hi_ch);
        man_ok    = bus.ch_mask[man_ch];
`else
        scan_ok   = 1'b1;
        scan_ch   = ptr;
        scan_last = (ptr == SW'(N - 1));
        man_ok    = 1'b1;
`endif
        cap_ch   = (bus.mode == MODE_MANUAL) ? man_ch : scan_ch;
        cap_last = (bus.mode == MODE_SCAN) && scan_last;
        cap_ok   = bus.en && ((bus.mode == MODE_SCAN) ? scan_ok : man_ok);
        do_cap   = cap_ok && ((state == IDLE) || bus.dout_ready);
        ptr_adv  = SW'(wrap_inc(32'(scan_ch), N));
    end

    mux_nto1 #(.N(N), .W(W)) u_mux (
        .din (bus.din),
        .sel (cap_ch),
        .y   (cap_data)
    );

    // Output register FSM: a held sample only moves when accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_last_q  <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            if (do_cap) begin
                dout_q      <= cap_data;
                dout_ch_q   <= cap_ch;
                dout_last_q <= cap_last;
                if (bus.mode == MODE_SCAN) ptr <= ptr_adv;
            end
            case (state)
                IDLE: begin
                    if (do_cap) begin
                        state        <= VALID;
                        dout_valid_q <= 1'b1;
                    end
                end
                VALID: begin
                    if (bus.dout_ready && !do_cap) begin
                        state        <= IDLE;
                        dout_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    dout_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_ch    = dout_ch_q;
    assign bus.dout_last  = dout_last_q;
    assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mux_scanner.sv
// Directed bench for mux_scanner: an N=4 instance driven from a vector table
// plus an N=5 instance for out-of-range manual selects.
module tb_mux_scanner;
    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    mux_scanner_if #(.N(4), .W(8)) if4 ();
    mux_scanner_if #(.N(5), .W(8)) if5 ();

    mux_scanner #(.N(4), .W(8)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    mux_scanner #(.N(5), .W(8)) dut5 (.clk(clk), .rst(rst), .bus(if5.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       mode;
        logic [1:0] sel;
        logic       ready;
        logic       alt;
        logic       exp_valid;
        logic [7:0] exp_dout;
        logic [1:0] exp_ch;
        logic       exp_last;
    } vec_t;

    localparam int NV = 20;
    vec_t vt [NV];

    localparam logic [31:0] DIN4_NORM = 32'hA3A2A1A0;
    localparam logic [31:0] DIN4_ALT  = 32'h53525150;
    localparam logic [39:0] DIN5_NORM = 40'hA4A3A2A1A0;

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic chk4(input string name, input int idx, input logic v, input logic [7:0] d,
                        input logic [1:0] c, input logic l);
        check({name, ".valid"}, idx, 32'(if4.dout_valid), 32'(v));
        check({name, ".dout"},  idx, 32'(if4.dout),       32'(d));
        check({name, ".ch"},    idx, 32'(if4.dout_ch),    32'(c));
        check({name, ".last"},  idx, 32'(if4.dout_last),  32'(l));
    endtask

    task automatic chk5(input string name, input int idx, input logic v, input logic [7:0] d,
                        input logic [2:0] c, input logic l);
        check({name, ".valid"}, idx, 32'(if5.dout_valid), 32'(v));
        check({name, ".dout"},  idx, 32'(if5.dout),       32'(d));
        check({name, ".ch"},    idx, 32'(if5.dout_ch),    32'(c));
        check({name, ".last"},  idx, 32'(if5.dout_last),  32'(l));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive5(input logic en, input logic mode, input logic [2:0] sel);
        if5.en = en; if5.mode = mode; if5.sel = sel; if5.dout_ready = 1'b1;
    endtask

    initial begin
        //          en  mode sel ry alt   v  dout   ch  last
        vt[0]  = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'hA0, 2'd0, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'hA1, 2'd1, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'hA2, 2'd2, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'hA3, 2'd3, 1'b1};
        vt[4]  = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'hA0, 2'd0, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'hA1, 2'd1, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd1, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd1, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd1, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'hA2, 2'd2, 1'b0};
        vt[10] = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 8'hA0, 2'd0, 1'b0};
        vt[11] = '{1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'hA2, 2'd2, 1'b0};
        vt[12] = '{1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b1, 8'hA3, 2'd3, 1'b0};
        vt[13] = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'hA3, 2'd3, 1'b1};
        vt[14] = '{1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 8'hA3, 2'd3, 1'b1};
        vt[15] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'hA3, 2'd3, 1'b1};
        vt[16] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd0, 1'b0};
        vt[17] = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd0, 1'b0};
        vt[18] = '{1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'hA2, 2'd2, 1'b0};
        vt[19] = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'hA1, 2'd1, 1'b0};

        rst = 1'b1;
        if4.en = 1'b0; if4.mode = 1'b1; if4.sel = '0; if4.dout_ready = 1'b0; if4.din = DIN4_NORM;
        if5.en = 1'b0; if5.mode = 1'b1; if5.sel = '0; if5.dout_ready = 1'b0; if5.din = DIN5_NORM;
`ifdef MUX_SCANNER_MASK_EN
        if4.ch_mask = '1;
        if5.ch_mask = '1;
`endif
        #3;
        chk4("reset", 0, 1'b0, 8'h00, 2'd0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table: scan pass with wrap, stall with changing din, manual, idle/resume.
        for (int i = 0; i < NV; i++) begin
            if4.en = vt[i].en; if4.mode = vt[i].mode; if4.sel = vt[i].sel;
            if4.dout_ready = vt[i].ready;
            if4.din = vt[i].alt ? DIN4_ALT : DIN4_NORM;
            tick();
            chk4("vec", i, vt[i].exp_valid, vt[i].exp_dout, vt[i].exp_ch, vt[i].exp_last);
        end

        // Reset pulsed while a sample is stalled.
        if4.en = 1'b1; if4.mode = 1'b1; if4.dout_ready = 1'b0;
        tick();
        chk4("stall", 0, 1'b1, 8'hA1, 2'd1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk4("rst_async", 0, 1'b0, 8'h00, 2'd0, 1'b0);
        tick();
        chk4("rst_held", 0, 1'b0, 8'h00, 2'd0, 1'b0);
        rst = 1'b0; if4.en = 1'b0; if4.dout_ready = 1'b1;
        tick();
        chk4("post_rst_en0", 0, 1'b0, 8'h00, 2'd0, 1'b0);
        if4.en = 1'b1;
        tick();
        chk4("post_rst_first", 0, 1'b1, 8'hA0, 2'd0, 1'b0);
        if4.en = 1'b0;
        tick();

        // N=5 instance: out-of-range manual select and ptr retention.
        drive5(1'b1, 1'b1, 3'd0); tick(); chk5("n5", 0, 1'b1, 8'hA0, 3'd0, 1'b0);
        drive5(1'b1, 1'b0, 3'd2); tick(); chk5("n5", 1, 1'b1, 8'hA2, 3'd2, 1'b0);
        drive5(1'b1, 1'b0, 3'd5); tick(); chk5("n5", 2, 1'b1, 8'hA0, 3'd0, 1'b0);
        drive5(1'b1, 1'b0, 3'd7); tick(); chk5("n5", 3, 1'b1, 8'hA0, 3'd0, 1'b0);
        drive5(1'b1, 1'b1, 3'd0); tick(); chk5("n5", 4, 1'b1, 8'hA1, 3'd1, 1'b0);
        drive5(1'b1, 1'b1, 3'd0); tick(); chk5("n5", 5, 1'b1, 8'hA2, 3'd2, 1'b0);
        drive5(1'b1, 1'b1, 3'd0); tick(); chk5("n5", 6, 1'b1, 8'hA3, 3'd3, 1'b0);
        drive5(1'b1, 1'b1, 3'd0); tick(); chk5("n5", 7, 1'b1, 8'hA4, 3'd4, 1'b1);
        drive5(1'b1, 1'b1, 3'd0); tick(); chk5("n5", 8, 1'b1, 8'hA0, 3'd0, 1'b0);
        drive5(1'b0, 1'b1, 3'd0); tick(); chk5("n5", 9, 1'b0, 8'hA0, 3'd0, 1'b0);

`ifdef MUX_SCANNER_MASK_EN
        // Masked scan skips disabled channels; masked manual select does nothing.
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        if4.ch_mask = 4'b1010; if4.en = 1'b1; if4.mode = 1'b1; if4.dout_ready = 1'b1;
        tick(); chk4("mask", 0, 1'b1, 8'hA1, 2'd1, 1'b0);
        tick(); chk4("mask", 1, 1'b1, 8'hA3, 2'd3, 1'b1);
        tick(); chk4("mask", 2, 1'b1, 8'hA1, 2'd1, 1'b0);
        if4.mode = 1'b0; if4.sel = 2'd0;
        tick(); chk4("mask", 3, 1'b0, 8'hA1, 2'd1, 1'b0);
        tick(); chk4("mask", 4, 1'b0, 8'hA1, 2'd1, 1'b0);
        if4.sel = 2'd3;
        tick(); chk4("mask", 5, 1'b1, 8'hA3, 2'd3, 1'b0);
        if4.ch_mask = 4'b0000; if4.mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mask0.valid", i, 32'(if4.dout_valid), 32'd0);
        end
        if4.mode = 1'b0;
        tick();
        check("mask0.valid_man", 0, 32'(if4.dout_valid), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_scanner.md
MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the number of input channels (N >= 2).
REQ-002 The block SHALL have parameter W, default 8, giving the data width per channel.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: sampling enable.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = manual select, 1 = auto-scan.
REQ-007 The block SHALL have port sel, input, $clog2(N) bits: the channel index used in manual mode.
REQ-008 The block SHALL have port din, input, N*W bits: channel k occupies din[k*W +: W].
REQ-009 The block SHALL have port dout_ready, input, 1 bit: downstream accept.
REQ-010 The block SHALL have port dout, output, W bits: the registered sample.
REQ-011 The block SHALL have port dout_valid, output, 1 bit: dout holds an unaccepted sample.
REQ-012 The block SHALL have port dout_ch, output, $clog2(N) bits: the channel index of dout.
REQ-013 The block SHALL have port dout_last, output, 1 bit: dout is the final channel of a scan pass.

Function
REQ-014 The FSM SHALL have two states: IDLE (dout_valid=0) and VALID (dout_valid=1).
REQ-015 A "capture" SHALL load dout, dout_ch and dout_last from the selected channel in one edge; the latency from selection to dout is 1 cycle.
REQ-016 In IDLE with en=1, the block SHALL capture and go to VALID; with en=0 it SHALL stay in IDLE and leave dout unchanged.
REQ-017 In VALID with dout_ready=0, dout, dout_ch and dout_last SHALL hold stable regardless of din, sel, mode and en.
REQ-018 In VALID with dout_ready=1 and en=1, the block SHALL capture the next channel on the same edge and stay in VALID, sustaining 1 sample per cycle.
REQ-019 In VALID with dout_ready=1 and en=0, the block SHALL go to IDLE.
REQ-020 In manual mode the selected channel SHALL be sel; if sel >= N, channel 0 SHALL be captured and dout_ch SHALL be 0.
REQ-021 In scan mode the selected channel SHALL be the pointer ptr, and ptr SHALL advance by 1 on each scan-mode capture, wrapping from N-1 to 0.
REQ-022 ptr SHALL NOT change on manual captures; returning to scan mode SHALL resume from the retained ptr.
REQ-023 dout_last SHALL be 1 only for a scan-mode capture of the last channel of the pass (N-1); it SHALL be 0 in manual mode.
REQ-024 A change of mode SHALL take effect at the next capture; a sample already held SHALL be unaffected.

Reset
REQ-025 While rst=1, the block SHALL be asynchronously in IDLE with ptr=0, dout=0, dout_ch=0, dout_valid=0 and dout_last=0.
REQ-026 Reset asserted during a stalled sample SHALL discard that sample.
REQ-027 After rst is released, the first capture SHALL occur on the first edge with en=1.

Configuration
REQ-028 When macro MUX_SCANNER_MASK_EN is defined, the block SHALL add port ch_mask, input, N bits, where 1 = channel enabled.
REQ-029 With MUX_SCANNER_MASK_EN, scan mode SHALL capture the next enabled channel at or after ptr, cyclically, and ptr SHALL become that channel + 1 (mod N).
REQ-030 With MUX_SCANNER_MASK_EN, dout_last SHALL mark the highest-index enabled channel.
REQ-031 With MUX_SCANNER_MASK_EN, a manual select of a masked channel SHALL perform no capture; the block SHALL behave as if en=0.
REQ-032 With MUX_SCANNER_MASK_EN and ch_mask all-zero, the block SHALL perform no capture in either mode.
REQ-033 Without MUX_SCANNER_MASK_EN, ch_mask SHALL be absent and every channel SHALL be enabled.

Structure
REQ-034 Package mux_scanner_pkg SHALL hold the state enum (IDLE, VALID) and the mode constants MODE_MANUAL=0 and MODE_SCAN=1.
REQ-035 The combinational N:1 select of W-bit data SHALL be a sub-module, mux_nto1, parametrised by N and W.

Verification (N=4, W=8, din channels = 8'hA0, 8'hA1, 8'hA2, 8'hA3)
REQ-036 Scan, dout_ready=1, en=1 held: dout SHALL read A0, A1, A2, A3, A0 on consecutive cycles, with dout_last=1 on A3 only.
REQ-037 Scan, dout_ready=0 for 3 cycles while holding A1, with din changed: dout SHALL stay A1; on ready, A2 SHALL follow.
REQ-038 Manual, sel=2 then sel=5 (out of range, using a 3-bit sel in an N=5 bench): dout SHALL read A2, then channel 0 with dout_ch=0; ptr SHALL be unchanged on return to scan.
REQ-039 rst pulsed mid-stall: dout_valid SHALL drop immediately; after release, scan SHALL restart at A0.
REQ-040 With MUX_SCANNER_MASK_EN and ch_mask=4'b1010, scan: dout SHALL read A1, A3, A1, with dout_last on A3; with ch_mask=0, dout_valid SHALL never assert.
